traffic: RTL and testbench

- Two-way intersection traffic-light controller: north-south (NS) and east-west (EW) approaches, each with a car-presence sensor.
- Core decision is a combinational next-direction function, NEXT = f(CURR, NSC, EWC).
- Around it sits a clocked phase state machine that sequences green, yellow and all-red clearance, with minimum- and maximum-green timing.
- Drives per-approach lamp outputs and sits directly under the intersection top level.

---
 rtl/traffic.sv | 136 +++++++++++++
 tb/tb_traffic.sv | 138 +++++++++++++
 2 files changed

// File: rtl/traffic.sv
// ---------------------------------------------------------------------------
// traffic -- two-way intersection light controller (NS / EW approaches).
//
// A combinational preference function picks which direction should hold
// right-of-way. A phase FSM runs the green -> yellow -> all-red -> green
// sequence around that function, with minimum and maximum green times.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous reset, active-high
//   NSC       in   north-south car present (synchronous to CLK)
//   EWC       in   east-west car present (synchronous to CLK)
//   CURR      out  direction holding right-of-way (0 = NS, 1 = EW)
//   NEXT      out  combinational preferred direction from CURR/NSC/EWC
//   NS_LIGHT  out  NS lamps, one-hot {R,Y,G}
//   EW_LIGHT  out  EW lamps, one-hot {R,Y,G}
//   PHASE     out  current state code
//
// state      | code | meaning
// -----------+------+-----------------------------------------------
// NS_GREEN   |  0   | NS green, EW red (reset state)
// NS_YELLOW  |  1   | NS yellow, EW red
// RED_TO_EW  |  2   | all red, clearing before EW gets green
// EW_GREEN   |  3   | EW green, NS red
// EW_YELLOW  |  4   | EW yellow, NS red
// RED_TO_NS  |  5   | all red, clearing before NS gets green
// (6, 7)     |  -   | illegal, recover to NS_GREEN on next edge
// ---------------------------------------------------------------------------
module traffic #(
   parameter int MIN_GREEN   = 4,
   parameter int MAX_GREEN   = 16,
   parameter int YELLOW_TIME = 3,
   parameter int RED_TIME    = 1,
   parameter int TW          = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       NSC,
   input  logic       EWC,
   output logic       CURR,
   output logic       NEXT,
   output logic [2:0] NS_LIGHT,
   output logic [2:0] EW_LIGHT,
   output logic [2:0] PHASE
);

   localparam logic [2:0] S_NS_GREEN  = 3'd0;
   localparam logic [2:0] S_NS_YELLOW = 3'd1;
   localparam logic [2:0] S_RED_TO_EW = 3'd2;
   localparam logic [2:0] S_EW_GREEN  = 3'd3;
   localparam logic [2:0] S_EW_YELLOW = 3'd4;
   localparam logic [2:0] S_RED_TO_NS = 3'd5;

   localparam logic [2:0] L_GREEN  = 3'b001;
   localparam logic [2:0] L_YELLOW = 3'b010;
   localparam logic [2:0] L_RED    = 3'b100;

   localparam logic [TW-1:0] T_MIN_M1 = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] T_MAX_M1 = TW'(MAX_GREEN - 1);
   localparam logic [TW-1:0] T_YEL_M1 = TW'(YELLOW_TIME - 1);
   localparam logic [TW-1:0] T_RED_M1 = TW'(RED_TIME - 1);

   logic [2:0]    r_state;
   logic [TW-1:0] r_timer;

   logic [2:0]    w_next_state;
   logic          w_curr;
   logic          w_next;
   logic          w_green;
   logic          w_opp_car;
   logic          w_green_exit;

   // Right-of-way moves only when the other side has a car and the current
   // side does not.
   assign w_curr = (r_state == S_EW_GREEN) || (r_state == S_EW_YELLOW) ||
                   (r_state == S_RED_TO_NS);
   assign w_next = w_curr ? ~(NSC & ~EWC) : (EWC & ~NSC);

   assign w_green   = (r_state == S_NS_GREEN) || (r_state == S_EW_GREEN);
   assign w_opp_car = (r_state == S_NS_GREEN) ? EWC : NSC;

   // The max-green term breaks the tie when both approaches keep a car
   // waiting, since the preference function alone would never switch.
   assign w_green_exit = (r_timer >= T_MIN_M1) &&
                         ((w_next != w_curr) ||
                          ((r_timer == T_MAX_M1) && w_opp_car));

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_NS_GREEN:  if (w_green_exit)         w_next_state = S_NS_YELLOW;
         S_NS_YELLOW: if (r_timer == T_YEL_M1)  w_next_state = S_RED_TO_EW;
         S_RED_TO_EW: if (r_timer == T_RED_M1)  w_next_state = S_EW_GREEN;
         S_EW_GREEN:  if (w_green_exit)         w_next_state = S_EW_YELLOW;
         S_EW_YELLOW: if (r_timer == T_YEL_M1)  w_next_state = S_RED_TO_NS;
         S_RED_TO_NS: if (r_timer == T_RED_M1)  w_next_state = S_NS_GREEN;
         default:                               w_next_state = S_NS_GREEN;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_NS_GREEN;
         r_timer <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_next_state != r_state) begin
            r_timer <= '0;
         end else if (w_green && (r_timer == T_MAX_M1)) begin
            r_timer <= r_timer;
         end else begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   always_comb begin
      NS_LIGHT = L_RED;
      EW_LIGHT = L_RED;
      case (r_state)
         S_NS_GREEN:  NS_LIGHT = L_GREEN;
         S_NS_YELLOW: NS_LIGHT = L_YELLOW;
         S_EW_GREEN:  EW_LIGHT = L_GREEN;
         S_EW_YELLOW: EW_LIGHT = L_YELLOW;
         default: begin
            NS_LIGHT = L_RED;
            EW_LIGHT = L_RED;
         end
      endcase
   end

   assign CURR  = w_curr;
   assign NEXT  = w_next;
   assign PHASE = r_state;

endmodule

// File: tb/tb_traffic.sv
module tb_traffic;

   logic       CLK;
   logic       RST;
   logic       NSC;
   logic       EWC;
   logic       CURR;
   logic       NEXT;
   logic [2:0] NS_LIGHT;
   logic [2:0] EW_LIGHT;
   logic [2:0] PHASE;

   int checks;
   int failures;

   traffic dut (
      .CLK      (CLK),
      .RST      (RST),
      .NSC      (NSC),
      .EWC      (EWC),
      .CURR     (CURR),
      .NEXT     (NEXT),
      .NS_LIGHT (NS_LIGHT),
      .EW_LIGHT (EW_LIGHT),
      .PHASE    (PHASE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hold reset across an edge, then release on a falling edge; the sample
   // taken right after release is cycle 0.
   task automatic do_reset(input logic nsc, input logic ewc);
      NSC = nsc;
      EWC = ewc;
      RST = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic chk_state(input string tag, input logic [2:0] ph, input logic cu,
                            input logic [2:0] ns, input logic [2:0] ew);
      chk({tag, "_phase"}, 32'(PHASE), 32'(ph));
      chk({tag, "_curr"},  32'(CURR),  32'(cu));
      chk({tag, "_ns"},    32'(NS_LIGHT), 32'(ns));
      chk({tag, "_ew"},    32'(EW_LIGHT), 32'(ew));
   endtask

   logic [2:0] exp_ph;

   initial begin
      checks   = 0;
      failures = 0;
      NSC = 1'b0;
      EWC = 1'b0;
      RST = 1'b1;

      // Reset state, NEXT with CURR=0 (reset held keeps NS_GREEN).
      #2;
      chk_state("reset", 3'd0, 1'b0, 3'b001, 3'b100);
      NSC = 0; EWC = 0; #1; chk("next_000", 32'(NEXT), 32'd0);
      NSC = 0; EWC = 1; #1; chk("next_001", 32'(NEXT), 32'd1);
      NSC = 1; EWC = 0; #1; chk("next_010", 32'(NEXT), 32'd0);
      NSC = 1; EWC = 1; #1; chk("next_011", 32'(NEXT), 32'd0);

      // EW car only: NS green 0-3, yellow 4-6, all red 7, EW green 8.
      do_reset(1'b0, 1'b1);
      for (int k = 0; k <= 8; k++) begin
         if (k <= 3)      chk_state("ewreq_g",  3'd0, 1'b0, 3'b001, 3'b100);
         else if (k <= 6) chk_state("ewreq_y",  3'd1, 1'b0, 3'b010, 3'b100);
         else if (k == 7) chk_state("ewreq_r",  3'd2, 1'b0, 3'b100, 3'b100);
         else             chk_state("ewreq_ew", 3'd3, 1'b1, 3'b100, 3'b001);
         if (k < 8) @(negedge CLK);
      end

      // NEXT with CURR=1, swept inside one low clock phase (timer < MIN).
      NSC = 0; EWC = 0; #1; chk("next_100", 32'(NEXT), 32'd1);
      NSC = 0; EWC = 1; #1; chk("next_101", 32'(NEXT), 32'd1);
      NSC = 1; EWC = 0; #1; chk("next_110", 32'(NEXT), 32'd0);
      NSC = 1; EWC = 1; #1; chk("next_111", 32'(NEXT), 32'd1);

      // NS car only from cycle 8: EW green 8-11, EW yellow at 12.
      NSC = 1; EWC = 0;
      repeat (3) @(negedge CLK);
      chk_state("nsreq_g11", 3'd3, 1'b1, 3'b100, 3'b001);
      @(negedge CLK);
      chk_state("nsreq_y12", 3'd4, 1'b1, 3'b100, 3'b010);

      // Asynchronous reset in EW_YELLOW, checked before any rising edge.
      #2 RST = 1'b1;
      #1;
      chk_state("async_rst", 3'd0, 1'b0, 3'b001, 3'b100);

      // No cars for 50 cycles: NS green holds.
      do_reset(1'b0, 1'b0);
      for (int k = 0; k < 50; k++) begin
         chk("idle_phase", 32'(PHASE), 32'd0);
         chk("idle_curr",  32'(CURR),  32'd0);
         @(negedge CLK);
      end

      // Both cars held: starvation guard switches at max green each way.
      do_reset(1'b1, 1'b1);
      for (int k = 0; k <= 40; k++) begin
         if (k < 16)       exp_ph = 3'd0;
         else if (k < 19)  exp_ph = 3'd1;
         else if (k == 19) exp_ph = 3'd2;
         else if (k < 36)  exp_ph = 3'd3;
         else if (k < 39)  exp_ph = 3'd4;
         else if (k == 39) exp_ph = 3'd5;
         else              exp_ph = 3'd0;
         chk($sformatf("both_c%0d", k), 32'(PHASE), 32'(exp_ph));
         @(negedge CLK);
      end

      // EW pulse at cycles 0-1 only: below min green, request cancelled.
      do_reset(1'b0, 1'b1);
      for (int k = 0; k < 30; k++) begin
         if (k == 2) EWC = 1'b0;
         chk("pulse_phase", 32'(PHASE), 32'd0);
         chk("pulse_ns",    32'(NS_LIGHT), 32'b001);
         @(negedge CLK);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
